// File: rtl/icb_arb_pkg.sv
// Shared types and helpers for the ICB arbiter: state enum, default
// parameter values and the select-width helper.
package icb_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_NUM_MASTERS    = 32'd5;
  localparam logic [15:0] DEF_HIPRI_MASK     = 16'h0010;
  localparam int unsigned DEF_RR_INIT        = 32'd0;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd1024;

  // Index width for n items, never below one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    if (n <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/icb_arb_rr_pick.sv
// Combinational rotating priority picker: returns the first index at or
// after 'start' (wrapping modulo N) whose req and mask bits are both set.
module icb_arb_rr_pick
  import icb_arb_pkg::*;
#(
  parameter int unsigned N = DEF_NUM_MASTERS,
  parameter int unsigned W = clog2_min1(N)
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [W:0]   pos_s;
  logic [W-1:0] pos_mod_s;
  logic         hit_s;

  // Walk the vector once from the start pointer; first eligible hit wins.
  always_comb begin
    found     = 1'b0;
    idx       = {W{1'b0}};
    pos_s     = {(W+1){1'b0}};
    pos_mod_s = {W{1'b0}};
    hit_s     = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      pos_s     = {1'b0, start} + (W+1)'(i);
      pos_mod_s = (pos_s >= (W+1)'(N)) ? W'(pos_s - (W+1)'(N)) : W'(pos_s);
      hit_s     = req[pos_mod_s] & mask[pos_mod_s] & ~found;
      idx       = hit_s ? pos_mod_s : idx;
      found     = found | hit_s;
    end
  end

endmodule

// File: rtl/icb_arbiter_param.sv
// ICB bus arbiter for NUM_MASTERS requesters sharing one master port.
// HIPRI_MASK masters win by fixed priority (highest index first); the rest
// share the bus round-robin. A grant is held until the owner pulses done.
// Optional grant watchdog: define ICB_ARB_TIMEOUT_EN to build the hold
// counter and the timeout/timeout_master outputs.
module icb_arbiter_param
  import icb_arb_pkg::*;
#(
  parameter int unsigned             NUM_MASTERS    = DEF_NUM_MASTERS,
  parameter logic [NUM_MASTERS-1:0]  HIPRI_MASK     = NUM_MASTERS'(DEF_HIPRI_MASK),
  parameter int unsigned             RR_INIT        = DEF_RR_INIT,
  parameter int unsigned             TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int unsigned            SEL_W          = clog2_min1(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] done,
  output logic [NUM_MASTERS-1:0] granted,
  output logic [SEL_W-1:0]       icb_sel,
  output logic                   bus_busy,
  output logic                   timeout,
  output logic [SEL_W-1:0]       timeout_master
);

  localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);

  arb_state_e             state_r, state_nxt_s;
  logic [SEL_W-1:0]       cur_r, cur_nxt_s;
  logic [NUM_MASTERS-1:0] granted_r, granted_nxt_s;
  logic [SEL_W-1:0]       rr_ptr_r, rr_ptr_eff_s;
  logic                   busy_r;

  logic                   done_cur_s;
  logic                   timeout_fire_s;
  logic                   release_s;
  logic                   bus_free_s;
  logic                   grant_issue_s;
  logic [SEL_W-1:0]       cur_plus1_s;

  logic [NUM_MASTERS-1:0] hp_req_s;
  logic                   hp_found_s;
  logic [SEL_W-1:0]       hp_idx_s;
  logic                   rr_found_s;
  logic [SEL_W-1:0]       rr_idx_s;

  assign done_cur_s  = (state_r == ARB_BUSY) & done[cur_r];
  assign release_s   = (state_r == ARB_BUSY) & (done_cur_s | timeout_fire_s);
  assign cur_plus1_s = (cur_r == SEL_W'(NUM_MASTERS - 1)) ? {SEL_W{1'b0}} : (cur_r + SEL_W'(1));
  // Releasing an RR master moves the pointer past it before re-arbitration,
  // so the finished master has lowest priority in the same-cycle search.
  assign rr_ptr_eff_s = (release_s & ~HIPRI_MASK[cur_r]) ? cur_plus1_s : rr_ptr_r;
  assign hp_req_s     = req & HIPRI_MASK;

  // Fixed-priority pick among high-priority requesters; highest index wins.
  always_comb begin
    hp_found_s = 1'b0;
    hp_idx_s   = {SEL_W{1'b0}};
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      hp_idx_s   = hp_req_s[i] ? SEL_W'(i) : hp_idx_s;
      hp_found_s = hp_found_s | hp_req_s[i];
    end
  end

  icb_arb_rr_pick #(
    .N (NUM_MASTERS),
    .W (SEL_W)
  ) u_rr_pick (
    .req   (req),
    .mask  (~HIPRI_MASK),
    .start (rr_ptr_eff_s),
    .found (rr_found_s),
    .idx   (rr_idx_s)
  );

  // Next-state and next-grant decode; arbitration only when the bus is free.
  always_comb begin
    state_nxt_s   = state_r;
    cur_nxt_s     = cur_r;
    granted_nxt_s = granted_r;
    grant_issue_s = 1'b0;
    case (state_r)
      ARB_IDLE: bus_free_s = 1'b1;
      ARB_BUSY: bus_free_s = release_s;
      default:  bus_free_s = 1'b1;
    endcase
    if (bus_free_s) begin
      if (hp_found_s) begin
        state_nxt_s   = ARB_BUSY;
        cur_nxt_s     = hp_idx_s;
        granted_nxt_s = ONE_HOT0 << hp_idx_s;
        grant_issue_s = 1'b1;
      end else if (rr_found_s) begin
        state_nxt_s   = ARB_BUSY;
        cur_nxt_s     = rr_idx_s;
        granted_nxt_s = ONE_HOT0 << rr_idx_s;
        grant_issue_s = 1'b1;
      end else begin
        state_nxt_s   = ARB_IDLE;
        granted_nxt_s = {NUM_MASTERS{1'b0}};
      end
    end else begin
      state_nxt_s   = state_r;
      granted_nxt_s = granted_r;
    end
  end

  // State, grant, select and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ARB_IDLE;
      cur_r     <= {SEL_W{1'b0}};
      granted_r <= {NUM_MASTERS{1'b0}};
      rr_ptr_r  <= SEL_W'(RR_INIT);
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cur_r     <= cur_nxt_s;
      granted_r <= granted_nxt_s;
      rr_ptr_r  <= rr_ptr_eff_s;
      busy_r    <= (state_nxt_s == ARB_BUSY);
    end
  end

  assign granted  = granted_r;
  assign icb_sel  = cur_r;
  assign bus_busy = busy_r;

`ifdef ICB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = clog2_min1(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] hold_cnt_r;
  logic             timeout_r;
  logic [SEL_W-1:0] timeout_master_r;

  // A late done in the expiry cycle takes precedence over the watchdog.
  assign timeout_fire_s = (state_r == ARB_BUSY) & ~done_cur_s &
                          (hold_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Hold counter restarts with each grant; timeout pulse and culprit capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_r       <= {CNT_W{1'b0}};
      timeout_r        <= 1'b0;
      timeout_master_r <= {SEL_W{1'b0}};
    end else begin
      if (grant_issue_s || (state_nxt_s == ARB_IDLE)) begin
        hold_cnt_r <= {CNT_W{1'b0}};
      end else begin
        hold_cnt_r <= hold_cnt_r + CNT_W'(1);
      end
      timeout_r <= timeout_fire_s;
      if (timeout_fire_s) begin
        timeout_master_r <= cur_r;
      end else begin
        timeout_master_r <= timeout_master_r;
      end
    end
  end

  assign timeout        = timeout_r;
  assign timeout_master = timeout_master_r;
`else
  assign timeout_fire_s = 1'b0;
  assign timeout        = 1'b0;
  assign timeout_master = {SEL_W{1'b0}};
`endif

endmodule
